// File: rtl/tdc_pkg.sv
// Shared sizing helpers and tdata field layout for the multi-channel TDC stamper.
package tdc_pkg;

  // Channel-number field width; a single-channel build still carries one bit.
  function automatic int chb_f(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

  // Full output word width: {ovf, chan, ts}.
  function automatic int dw_f(input int nch, input int cw);
    return 1 + chb_f(nch) + cw;
  endfunction

  // Timestamp sits at the bottom of the word.
  localparam int TS_LSB = 0;

  // Channel index sits directly above the timestamp.
  function automatic int ch_lsb_f(input int cw);
    return cw;
  endfunction

  // Overflow flag is the most significant bit.
  function automatic int ovf_bit_f(input int nch, input int cw);
    return dw_f(nch, cw) - 1;
  endfunction

endpackage

// File: rtl/tdc_stamp_chan.sv
// One TDC channel: input synchronizer, rising-edge detect, edge divider and a one-entry timestamp slot.
module tdc_stamp_chan
  import tdc_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter int DIV_BITS      = 16,
  parameter int FF_SYNC_DEPTH = 2
) (
  input  logic                     i_clk_tdc,
  input  logic                     rst_tdc,
  input  logic                     i_ch,
  input  logic                     i_en,
  input  logic [DIV_BITS-1:0]      i_div_n,
  input  logic [COUNTER_WIDTH-1:0] i_ts,
  input  logic                     i_grant,
  output logic                     o_full,
  output logic                     o_slot_ovf,
  output logic [COUNTER_WIDTH-1:0] o_slot_ts,
  output logic                     o_ovf_evt
);

  logic [FF_SYNC_DEPTH-1:0] r_sync;
  logic                     r_sync_d;
  logic [DIV_BITS-1:0]      r_div_cnt;
  logic                     r_full;
  logic                     r_slot_ovf;
  logic [COUNTER_WIDTH-1:0] r_slot_ts;
  logic                     w_edge;
  logic                     w_event;

  assign w_edge    = r_sync[FF_SYNC_DEPTH-1] & ~r_sync_d;
  assign w_event   = w_edge & i_en & (r_div_cnt >= i_div_n);
  assign o_ovf_evt = w_event & r_full & ~i_grant;
  assign o_full    = r_full;
  assign o_slot_ovf = r_slot_ovf;
  assign o_slot_ts = r_slot_ts;

  // Shift the asynchronous input through the synchronizer and keep a delayed copy for edge detect.
  always_ff @(posedge i_clk_tdc or posedge rst_tdc) begin
    if (rst_tdc) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= (r_sync << 1) | FF_SYNC_DEPTH'(i_ch);
      r_sync_d <= r_sync[FF_SYNC_DEPTH-1];
    end
  end

  // Count edges up to the divide value; a counter already past a lowered divide value fires on the next edge.
  always_ff @(posedge i_clk_tdc or posedge rst_tdc) begin
    if (rst_tdc) begin
      r_div_cnt <= '0;
    end else if (!i_en) begin
      r_div_cnt <= '0;
    end else if (w_edge) begin
      r_div_cnt <= (r_div_cnt >= i_div_n) ? '0 : r_div_cnt + DIV_BITS'(1);
    end
  end

  // Capture the timestamp into the slot; an event hitting a full, ungranted slot keeps the old stamp and flags overflow.
  always_ff @(posedge i_clk_tdc or posedge rst_tdc) begin
    if (rst_tdc) begin
      r_full     <= 1'b0;
      r_slot_ovf <= 1'b0;
      r_slot_ts  <= '0;
    end else if (w_event && (!r_full || i_grant)) begin
      r_full     <= 1'b1;
      r_slot_ovf <= 1'b0;
      r_slot_ts  <= i_ts;
    end else if (w_event) begin
      r_slot_ovf <= 1'b1;
    end else if (i_grant) begin
      r_full     <= 1'b0;
      r_slot_ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/tdc_mchan_stamper.sv
// Multi-channel TDC stamper: shared timestamp counter, per-channel stampers, round-robin arbiter and AXI-S output register.
module tdc_mchan_stamper
  import tdc_pkg::*;
#(
  parameter int NCH           = 4,
  parameter int COUNTER_WIDTH = 32,
  parameter int DIV_BITS      = 16,
  parameter int FF_SYNC_DEPTH = 2,
  localparam int CHB          = chb_f(NCH),
  localparam int DW           = dw_f(NCH, COUNTER_WIDTH)
) (
  input  logic                    i_clk_tdc,
  input  logic                    rst_tdc,
  input  logic [NCH-1:0]          i_ch,
  input  logic [NCH-1:0]          i_en,
  input  logic [NCH*DIV_BITS-1:0] i_div_n,
  input  logic                    i_ovf_clr,
  output logic [NCH-1:0]          o_ovf,
  output logic [DW-1:0]           o_m_axis_tdata,
  output logic                    o_m_axis_tvalid,
  input  logic                    i_m_axis_tready
);

  localparam int CH_LSB  = ch_lsb_f(COUNTER_WIDTH);
  localparam int OVF_BIT = ovf_bit_f(NCH, COUNTER_WIDTH);

  logic [COUNTER_WIDTH-1:0] r_ts;
  logic [NCH-1:0]           r_ovf;
  logic [DW-1:0]            r_tdata;
  logic                     r_tvalid;
  logic [CHB-1:0]           r_last;
  logic [NCH-1:0]           w_full;
  logic [NCH-1:0]           w_slot_ovf;
  logic [NCH-1:0]           w_ovf_evt;
  logic [NCH-1:0]           w_grant;
  logic [COUNTER_WIDTH-1:0] w_slot_ts [NCH];
  logic [CHB-1:0]           w_sel;
  logic                     w_found;
  logic                     w_can_load;

  assign w_can_load      = !r_tvalid || i_m_axis_tready;
  assign o_ovf           = r_ovf;
  assign o_m_axis_tdata  = r_tdata;
  assign o_m_axis_tvalid = r_tvalid;

  // Free-running timestamp counter; wraps silently.
  always_ff @(posedge i_clk_tdc or posedge rst_tdc) begin
    if (rst_tdc) r_ts <= '0;
    else         r_ts <= r_ts + COUNTER_WIDTH'(1);
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    tdc_stamp_chan #(
      .COUNTER_WIDTH(COUNTER_WIDTH),
      .DIV_BITS     (DIV_BITS),
      .FF_SYNC_DEPTH(FF_SYNC_DEPTH)
    ) u_chan (
      .i_clk_tdc (i_clk_tdc),
      .rst_tdc   (rst_tdc),
      .i_ch      (i_ch[c]),
      .i_en      (i_en[c]),
      .i_div_n   (i_div_n[c*DIV_BITS +: DIV_BITS]),
      .i_ts      (r_ts),
      .i_grant   (w_grant[c]),
      .o_full    (w_full[c]),
      .o_slot_ovf(w_slot_ovf[c]),
      .o_slot_ts (w_slot_ts[c]),
      .o_ovf_evt (w_ovf_evt[c])
    );
  end

  // Round-robin pick: first full slot strictly after the last granted one, granted only when the output can take it.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last;
    w_grant = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (!w_found && w_full[(int'(r_last) + k) % NCH]) begin
        w_found = 1'b1;
        w_sel   = CHB'((int'(r_last) + k) % NCH);
      end
    end
    for (int c = 0; c < NCH; c++) begin
      w_grant[c] = w_found && w_can_load && (w_sel == CHB'(c));
    end
  end

  // Output register loads the granted slot; holds its word until accepted. Arbiter pointer starts at the last channel so channel 0 goes first.
  always_ff @(posedge i_clk_tdc or posedge rst_tdc) begin
    if (rst_tdc) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_last   <= CHB'(NCH - 1);
    end else if (w_found && w_can_load) begin
      r_tvalid                         <= 1'b1;
      r_tdata[OVF_BIT]                 <= w_slot_ovf[w_sel];
      r_tdata[CH_LSB +: CHB]           <= w_sel;
      r_tdata[TS_LSB +: COUNTER_WIDTH] <= w_slot_ts[w_sel];
      r_last                           <= w_sel;
    end else if (i_m_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  // Sticky overflow flags; a new overflow wins over a simultaneous clear.
  always_ff @(posedge i_clk_tdc or posedge rst_tdc) begin
    if (rst_tdc) r_ovf <= '0;
    else         r_ovf <= (r_ovf & ~{NCH{i_ovf_clr}}) | w_ovf_evt;
  end

endmodule

// File: tb/tb_tdc_mchan_stamper.sv
// Directed self-checking bench for tdc_mchan_stamper (default build plus a 4-bit counter build for wrap).
module tb_tdc_mchan_stamper;

  logic        clk;
  logic        rst;
  logic [3:0]  ch;
  logic [3:0]  en;
  logic [63:0] divN;
  logic        ovfClr;
  logic [3:0]  ovf;
  logic [34:0] tdata;
  logic        tvalid;
  logic        tready;

  logic [3:0]  chS;
  logic [3:0]  enS;
  logic [15:0] divS;
  logic        ovfClrS;
  logic [3:0]  ovfS;
  logic [6:0]  tdataS;
  logic        tvalidS;
  logic        treadyS;

  int          tbCnt;
  int          nChecks;
  int          nPass;
  logic [34:0] words[$];

  tdc_mchan_stamper dut (
    .i_clk_tdc      (clk),
    .rst_tdc        (rst),
    .i_ch           (ch),
    .i_en           (en),
    .i_div_n        (divN),
    .i_ovf_clr      (ovfClr),
    .o_ovf          (ovf),
    .o_m_axis_tdata (tdata),
    .o_m_axis_tvalid(tvalid),
    .i_m_axis_tready(tready)
  );

  tdc_mchan_stamper #(.NCH(4), .COUNTER_WIDTH(4), .DIV_BITS(4), .FF_SYNC_DEPTH(2)) dutSmall (
    .i_clk_tdc      (clk),
    .rst_tdc        (rst),
    .i_ch           (chS),
    .i_en           (enS),
    .i_div_n        (divS),
    .i_ovf_clr      (ovfClrS),
    .o_ovf          (ovfS),
    .o_m_axis_tdata (tdataS),
    .o_m_axis_tvalid(tvalidS),
    .i_m_axis_tready(treadyS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count since reset release: the value the timestamp counter should hold this cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) tbCnt <= 0;
    else     tbCnt <= tbCnt + 1;
  end

  // Record every accepted output word, sampled just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (!rst && tvalid && tready) words.push_back(tdata);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; ch = '0; chS = '0; ovfClr = 1'b0; ovfClrS = 1'b0;
    en = 4'hF; enS = 4'hF; divN = '0; divS = '0; tready = 1'b1; treadyS = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    words.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    nChecks++; if (tvalid !== 1'b0) $display("[TB] FAIL reset_tvalid: got %b want 0", tvalid); else nPass++;
    nChecks++; if (tdata !== 35'd0) $display("[TB] FAIL reset_tdata: got %h want 0", tdata); else nPass++;
    nChecks++; if (ovf !== 4'd0) $display("[TB] FAIL reset_ovf: got %b want 0", ovf); else nPass++;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single_edge();
    int c0;
    logic [34:0] expW;
    doReset();
    c0 = tbCnt;
    ch[2] = 1'b1;
    expW = {1'b0, 2'd2, 32'(c0 + 2)};
    tick(3);
    nChecks++; if (tvalid !== 1'b0) $display("[TB] FAIL single_early_tvalid: got %b want 0", tvalid); else nPass++;
    tick(1);
    nChecks++; if (tvalid !== 1'b1) $display("[TB] FAIL single_tvalid: got %b want 1", tvalid); else nPass++;
    nChecks++; if (tdata !== expW) $display("[TB] FAIL single_tdata: got %h want %h", tdata, expW); else nPass++;
    ch[2] = 1'b0;
    tick(4);
    nChecks++; if (words.size() !== 1) $display("[TB] FAIL single_count: got %0d want 1", words.size()); else nPass++;
  endtask

  task automatic test_all_channels();
    int c0;
    logic [34:0] expW;
    doReset();
    c0 = tbCnt;
    ch = 4'hF;
    tick(2);
    ch = 4'h0;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      expW = {1'b0, 2'(i), 32'(c0 + 2)};
      nChecks++; if (tvalid !== 1'b1) $display("[TB] FAIL all_tvalid%0d: got %b want 1", i, tvalid); else nPass++;
      nChecks++; if (tdata !== expW) $display("[TB] FAIL all_word%0d: got %h want %h", i, tdata, expW); else nPass++;
      tick(1);
    end
    nChecks++; if (tvalid !== 1'b0) $display("[TB] FAIL all_end_tvalid: got %b want 0", tvalid); else nPass++;
  endtask

  task automatic test_divider();
    int cAt[9];
    logic [34:0] expW;
    logic [34:0] gotW;
    doReset();
    divN[16 +: 16] = 16'd2;
    for (int k = 0; k < 9; k++) begin
      cAt[k] = tbCnt;
      ch[1] = 1'b1;
      tick(2);
      ch[1] = 1'b0;
      tick(2);
    end
    tick(4);
    nChecks++; if (words.size() !== 3) $display("[TB] FAIL div_count: got %0d want 3", words.size()); else nPass++;
    for (int j = 0; j < 3; j++) begin
      expW = {1'b0, 2'd1, 32'(cAt[3*j + 2] + 2)};
      gotW = (words.size() > j) ? words[j] : 'x;
      nChecks++; if (gotW !== expW) $display("[TB] FAIL div_word%0d: got %h want %h", j, gotW, expW); else nPass++;
    end
    divN = '0;
  endtask

  task automatic test_overflow();
    int c1;
    logic [34:0] expA;
    logic [34:0] expB;
    logic [34:0] gotW;
    doReset();
    tready = 1'b0;
    c1 = tbCnt;
    for (int k = 0; k < 3; k++) begin
      ch[0] = 1'b1;
      tick(2);
      ch[0] = 1'b0;
      tick(2);
    end
    expA = {1'b0, 2'd0, 32'(c1 + 2)};
    expB = {1'b1, 2'd0, 32'(c1 + 6)};
    nChecks++; if (ovf !== 4'b0001) $display("[TB] FAIL ovf_flag_set: got %b want 0001", ovf); else nPass++;
    nChecks++; if (tvalid !== 1'b1) $display("[TB] FAIL ovf_hold_tvalid: got %b want 1", tvalid); else nPass++;
    nChecks++; if (tdata !== expA) $display("[TB] FAIL ovf_hold_tdata: got %h want %h", tdata, expA); else nPass++;
    tick(2);
    nChecks++; if (tdata !== expA) $display("[TB] FAIL ovf_stable_tdata: got %h want %h", tdata, expA); else nPass++;
    tready = 1'b1;
    tick(4);
    nChecks++; if (words.size() !== 2) $display("[TB] FAIL ovf_count: got %0d want 2", words.size()); else nPass++;
    gotW = (words.size() > 0) ? words[0] : 'x;
    nChecks++; if (gotW !== expA) $display("[TB] FAIL ovf_word0: got %h want %h", gotW, expA); else nPass++;
    gotW = (words.size() > 1) ? words[1] : 'x;
    nChecks++; if (gotW !== expB) $display("[TB] FAIL ovf_word1: got %h want %h", gotW, expB); else nPass++;
    nChecks++; if (ovf !== 4'b0001) $display("[TB] FAIL ovf_sticky: got %b want 0001", ovf); else nPass++;
    ovfClr = 1'b1;
    tick(1);
    ovfClr = 1'b0;
    nChecks++; if (ovf !== 4'b0000) $display("[TB] FAIL ovf_cleared: got %b want 0000", ovf); else nPass++;
  endtask

  task automatic test_wrap();
    int guard;
    doReset();
    guard = 0;
    while ((tbCnt % 16) != 13 && guard < 40) begin
      tick(1);
      guard++;
    end
    nChecks++; if ((tbCnt % 16) != 13) $display("[TB] FAIL wrap_align: got %0d want 13", tbCnt % 16); else nPass++;
    chS[0] = 1'b1;
    tick(1);
    chS[1] = 1'b1;
    tick(3);
    nChecks++; if (tdataS !== 7'b0_00_1111) $display("[TB] FAIL wrap_ts15: got %b want 0001111", tdataS); else nPass++;
    tick(1);
    nChecks++; if (tdataS !== 7'b0_01_0000) $display("[TB] FAIL wrap_ts0: got %b want 0010000", tdataS); else nPass++;
    chS = '0;
    tick(2);
  endtask

  task automatic test_reset_mid();
    doReset();
    tready = 1'b0;
    ch[1] = 1'b1;
    ch[3] = 1'b1;
    tick(2);
    ch = '0;
    tick(2);
    nChecks++; if (tvalid !== 1'b1) $display("[TB] FAIL mid_pre_tvalid: got %b want 1", tvalid); else nPass++;
    rst = 1'b1;
    #1;
    nChecks++; if (tvalid !== 1'b0) $display("[TB] FAIL mid_async_tvalid: got %b want 0", tvalid); else nPass++;
    tick(2);
    rst = 1'b0;
    tready = 1'b1;
    words.delete();
    tick(10);
    nChecks++; if (words.size() !== 0) $display("[TB] FAIL mid_stale_words: got %0d want 0", words.size()); else nPass++;
    nChecks++; if (tvalid !== 1'b0) $display("[TB] FAIL mid_post_tvalid: got %b want 0", tvalid); else nPass++;
  endtask

  initial begin
    nChecks = 0;
    nPass = 0;
    rst = 1'b1; ch = '0; chS = '0; en = 4'hF; enS = 4'hF; divN = '0; divS = '0;
    ovfClr = 1'b0; ovfClrS = 1'b0; tready = 1'b1; treadyS = 1'b1;
    $display("[TB] starting tdc_mchan_stamper bench");
    test_reset();
    test_single_edge();
    test_all_channels();
    test_divider();
    test_overflow();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
